// File: rtl/mult_error_monitor.sv
// Error-distance accumulator for an 8x8 approximate multiplier.
// Collects sum, nonzero count and max of |a*b - r_approx| per window.
module mult_error_monitor #(
  parameter int WINDOW_LOG2 = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              a,
  input  logic [7:0]              b,
  input  logic [15:0]             r_approx,
  output logic                    busy,
  output logic                    done,
  output logic [16+WINDOW_LOG2-1:0] sum_ed,
  output logic [WINDOW_LOG2:0]    err_count,
  output logic [15:0]             max_ed
);

  localparam int W = WINDOW_LOG2;
  localparam logic [W:0] LAST = (W+1)'((1 << W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t      state, state_n;
  logic [W:0]  cnt;
  logic [1:0]  dcnt;
  logic        accept;
  logic        v1;
  logic [15:0] ed1;
  logic [15:0] exact;
  logic [16:0] diff;
  logic [16:0] mag;
  logic        clr;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign accept   = in_valid && in_ready;
  assign clr      = start && ((state == IDLE) || (state == FIN));

  assign exact = 16'(a) * 16'(b);
  assign diff  = {1'b0, exact} - {1'b0, r_approx};
  // two's-complement magnitude; always fits in 16 bits
  assign mag   = diff[16] ? (~diff + 17'd1) : diff;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = RUN;
      RUN:   if (accept && cnt == LAST) state_n = DRAIN;
      DRAIN: if (dcnt == 2'd2) state_n = FIN;
      FIN:   if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == DRAIN) && (dcnt == 2'd2);
      if (state == DRAIN) dcnt <= dcnt + 2'd1;
      else                dcnt <= '0;
      if (clr)         cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      ed1 <= '0;
    end else begin
      v1  <= accept;
      ed1 <= mag[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_ed    <= '0;
      err_count <= '0;
      max_ed    <= '0;
    end else if (clr) begin
      sum_ed    <= '0;
      err_count <= '0;
      max_ed    <= '0;
    end else if (v1) begin
      sum_ed    <= sum_ed + {{W{1'b0}}, ed1};
      err_count <= err_count + (W+1)'(ed1 != 16'd0);
      if (ed1 > max_ed) max_ed <= ed1;
    end
  end

endmodule

// File: tb/tb_mult_error_monitor.sv
// Directed bench for mult_error_monitor.
// Small window instance plus a full-space sweep instance.
module tb_mult_error_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start2 = 1'b0;
  logic        start16 = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] r_approx = '0;

  logic        in_ready2, busy2, done2;
  logic [17:0] sum2;
  logic [2:0]  err2;
  logic [15:0] max2;

  logic        in_ready16, busy16, done16;
  logic [31:0] sum16;
  logic [16:0] err16;
  logic [15:0] max16;

  int nchk = 0;
  int nerr = 0;
  int ndone2 = 0;
  int n;
  int d0;

  always #5 clk = ~clk;

  always @(posedge clk) if (done2) ndone2++;

  mult_error_monitor #(.WINDOW_LOG2(2)) u2 (
    .clk(clk), .rst(rst), .start(start2),
    .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .r_approx(r_approx),
    .busy(busy2), .done(done2),
    .sum_ed(sum2), .err_count(err2), .max_ed(max2)
  );

  mult_error_monitor #(.WINDOW_LOG2(16)) u16 (
    .clk(clk), .rst(rst), .start(start16),
    .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .r_approx(r_approx),
    .busy(busy16), .done(done16),
    .sum_ed(sum16), .err_count(err16), .max_ed(max16)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] x,
                      input logic [7:0] y,
                      input logic [15:0] r);
    @(negedge clk);
    a = x; b = y; r_approx = r;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse2();
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
  endtask

  // edges counted from the edge after the last accept
  task automatic wait_done(input bit big, output int k);
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(posedge clk); #1;
      k++;
      seen = big ? done16 : done2;
    end
    if (!seen) chk("done_timeout", 32'(k), 32'd0);
  endtask

  task automatic window_541(input bit gaps);
    send(15, 15, 200);     if (gaps) idle(3);
    send(255, 255, 65535); if (gaps) idle(3);
    send(10, 10, 100);     if (gaps) idle(3);
    send(2, 3, 0);
    idle(1);
  endtask

  initial begin
    #12;
    chk("rst_sum", 32'(sum2), 0);
    chk("rst_err", 32'(err2), 0);
    chk("rst_max", 32'(max2), 0);
    chk("rst_rdy", 32'(in_ready2), 0);
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_done", 32'(done2), 0);
    @(negedge clk); rst = 1'b0;

    // exact products
    pulse2();
    chk("t1_rdy", 32'(in_ready2), 1);
    send(3, 5, 15);
    send(255, 255, 65025);
    send(0, 9, 0);
    send(16, 16, 256);
    idle(1);
    chk("t1_rdy_low", 32'(in_ready2), 0);
    chk("t1_busy", 32'(busy2), 1);
    wait_done(1'b0, n);
    chk("t1_lat", 32'(n), 3);
    chk("t1_sum", 32'(sum2), 0);
    chk("t1_err", 32'(err2), 0);
    chk("t1_max", 32'(max2), 0);

    // mixed errors, back-to-back
    pulse2();
    d0 = ndone2;
    window_541(1'b0);
    wait_done(1'b0, n);
    chk("t2_lat", 32'(n), 3);
    chk("t2_sum", 32'(sum2), 541);
    chk("t2_err", 32'(err2), 3);
    chk("t2_max", 32'(max2), 510);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_pulses", 32'(ndone2 - d0), 1);
    chk("t2_hold", 32'(sum2), 541);
    chk("t2_done_lo", 32'(done2), 0);

    // same samples with gaps
    pulse2();
    window_541(1'b1);
    wait_done(1'b0, n);
    chk("t3_lat", 32'(n), 3);
    chk("t3_sum", 32'(sum2), 541);
    chk("t3_err", 32'(err2), 3);
    chk("t3_max", 32'(max2), 510);

    // async reset mid-window
    pulse2();
    d0 = ndone2;
    send(15, 15, 200);
    send(255, 255, 65535);
    @(negedge clk); in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t4_sum", 32'(sum2), 0);
    chk("t4_err", 32'(err2), 0);
    chk("t4_max", 32'(max2), 0);
    chk("t4_rdy", 32'(in_ready2), 0);
    chk("t4_busy", 32'(busy2), 0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_nodone", 32'(ndone2 - d0), 0);
    chk("t4_idle_rdy", 32'(in_ready2), 0);
    pulse2();
    window_541(1'b0);
    wait_done(1'b0, n);
    chk("t4_sum2", 32'(sum2), 541);
    chk("t4_err2", 32'(err2), 3);

    // start in DONE clears; start in RUN ignored
    pulse2();
    chk("t5_clr_sum", 32'(sum2), 0);
    chk("t5_clr_max", 32'(max2), 0);
    send(15, 15, 200);
    send(255, 255, 65535);
    idle(3);
    chk("t5_part", 32'(sum2), 535);
    pulse2();
    idle(2);
    chk("t5_ign_sum", 32'(sum2), 535);
    chk("t5_ign_rdy", 32'(in_ready2), 1);
    send(10, 10, 100);
    send(2, 3, 0);
    idle(1);
    chk("t5_rdy_low", 32'(in_ready2), 0);
    wait_done(1'b0, n);
    chk("t5_lat", 32'(n), 3);
    chk("t5_sum", 32'(sum2), 541);
    chk("t5_err", 32'(err2), 3);

    // full operand sweep, off by one everywhere
    @(negedge clk); start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        send(8'(i), 8'(j), 16'(i * j + 1));
      end
    end
    idle(1);
    chk("t6_rdy_low", 32'(in_ready16), 0);
    wait_done(1'b1, n);
    chk("t6_lat", 32'(n), 3);
    chk("t6_sum", sum16, 65536);
    chk("t6_err", 32'(err16), 65536);
    chk("t6_max", 32'(max16), 1);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
